serial_frame_transmitter: RTL

SERIAL_FRAME_TRANSMITTER -- requirements
Module: serial_frame_transmitter

---
 rtl/serial_frame_transmitter.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_frame_transmitter.sv
// Serial frame transmitter: "110011" preamble, MSB-first payload,
// then a fixed idle gap before the next frame can be accepted.
module serial_frame_transmitter #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              a,
  output logic              valid,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    GAP
  } state_t;

  localparam logic [5:0] PRE   = 6'b110011;
  localparam logic [4:0] LAST  = 5'(DATA_W - 1);
  localparam logic [2:0] GLAST = 3'(GAP_CYCLES - 1);

  state_t            state;
  logic [DATA_W-1:0] sr;
  logic [2:0]        pcnt;
  logic [4:0]        bcnt;
  logic [2:0]        gcnt;

  assign ready = (state == IDLE);

  // a/valid/done always describe the bit being shown in the current cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      pcnt  <= '0;
      bcnt  <= '0;
      gcnt  <= '0;
      a     <= 1'b0;
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= PREAMBLE;
            sr    <= data;
            pcnt  <= '0;
            a     <= PRE[5];
            valid <= 1'b1;
          end else begin
            a     <= 1'b0;
            valid <= 1'b0;
          end
        end
        PREAMBLE: begin
          if (pcnt == 3'd5) begin
            state <= PAYLOAD;
            pcnt  <= '0;
            bcnt  <= LAST;
            a     <= sr[DATA_W-1];
            sr    <= sr << 1;
            done  <= (DATA_W == 1);
          end else begin
            pcnt <= pcnt + 3'd1;
            a    <= PRE[3'd4 - pcnt];
          end
        end
        PAYLOAD: begin
          if (bcnt == 5'd0) begin
            a     <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b0;
            sr    <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
              gcnt  <= GLAST;
            end else begin
              state <= IDLE;
            end
          end else begin
            bcnt <= bcnt - 5'd1;
            a    <= sr[DATA_W-1];
            sr   <= sr << 1;
            done <= (bcnt == 5'd1);
          end
        end
        GAP: begin
          if (gcnt == 3'd0) state <= IDLE;
          else gcnt <= gcnt - 3'd1;
        end
        default: begin
          state <= IDLE;
          a     <= 1'b0;
          valid <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
